// File: rtl/tdc_edge_bank.sv
// rtl/tdc_edge_bank.sv - multi-channel synchronised, glitch-filtered hit edge detector with dead-time holdoff
//
// Ports:
//   iClk      sampling clock, all logic on rising edge
//   iRst_n    asynchronous active-low reset
//   iEn       global enable for event generation (synchronisers/filters always track)
//   iMode     per-channel mode, [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both
//   iFilt     consecutive cycles required to accept a level change (0 == 1)
//   iDead     holdoff cycles after an accepted event (0 = none)
//   iClrMiss  clears all oMiss bits (a same-cycle set wins)
//   iHit      asynchronous hit inputs
//   oRise     one-cycle pulse on an accepted rising edge
//   oFall     one-cycle pulse on an accepted falling edge
//   oEvent    oRise | oFall, registered
//   oLevel    filtered level per channel
//   oMiss     sticky: an enabled edge was suppressed by holdoff
module tdc_edge_bank #(
  parameter int NCH    = 4,
  parameter int SYNC   = 2,
  parameter int FILT_W = 4,
  parameter int DEAD_W = 8
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iEn,
  input  logic [2*NCH-1:0]  iMode,
  input  logic [FILT_W-1:0] iFilt,
  input  logic [DEAD_W-1:0] iDead,
  input  logic              iClrMiss,
  input  logic [NCH-1:0]    iHit,
  output logic [NCH-1:0]    oRise,
  output logic [NCH-1:0]    oFall,
  output logic [NCH-1:0]    oEvent,
  output logic [NCH-1:0]    oLevel,
  output logic [NCH-1:0]    oMiss
);

  localparam logic [FILT_W:0]   FC_ONE_W = (FILT_W+1)'(1);
  localparam logic [FILT_W-1:0] FC_ONE   = FILT_W'(1);
  localparam logic [DEAD_W-1:0] DC_ONE   = DEAD_W'(1);

  logic [SYNC-1:0]   sync_q [NCH];
  logic [FILT_W-1:0] fc_q   [NCH];
  logic [FILT_W-1:0] fc_d   [NCH];
  logic [DEAD_W-1:0] dc_q   [NCH];
  logic [DEAD_W-1:0] dc_d   [NCH];

  logic [NCH-1:0] lvl_q, lvl_d;
  logic [NCH-1:0] rise_q, rise_d;
  logic [NCH-1:0] fall_q, fall_d;
  logic [NCH-1:0] evt_q;
  logic [NCH-1:0] miss_q, miss_d;

  logic [NCH-1:0] s_w;
  logic [NCH-1:0] raw_rise, raw_fall;
  logic [NCH-1:0] want, accept;

  // Threshold of 0 behaves as 1; one extra bit so fc+1 never wraps in the compare.
  logic [FILT_W:0] thr;
  assign thr = (iFilt == '0) ? FC_ONE_W : {1'b0, iFilt};

  always_comb begin
    lvl_d    = lvl_q;
    rise_d   = '0;
    fall_d   = '0;
    miss_d   = miss_q & ~{NCH{iClrMiss}};
    s_w      = '0;
    raw_rise = '0;
    raw_fall = '0;
    want     = '0;
    accept   = '0;
    for (int c = 0; c < NCH; c++) begin
      fc_d[c] = fc_q[c];
      dc_d[c] = dc_q[c];
      s_w[c]  = sync_q[c][SYNC-1];

      // Glitch filter: a partially advanced count is kept across iFilt changes.
      if (s_w[c] == lvl_q[c]) begin
        fc_d[c] = '0;
      end else if (({1'b0, fc_q[c]} + FC_ONE_W) >= thr) begin
        lvl_d[c]    = s_w[c];
        fc_d[c]     = '0;
        raw_rise[c] = s_w[c];
        raw_fall[c] = ~s_w[c];
      end else begin
        fc_d[c] = fc_q[c] + FC_ONE;
      end

      want[c]   = (raw_rise[c] & iMode[2*c]) | (raw_fall[c] & iMode[2*c+1]);
      accept[c] = iEn & want[c] & (dc_q[c] == '0);
      rise_d[c] = accept[c] & raw_rise[c];
      fall_d[c] = accept[c] & raw_fall[c];

      // Only edges that would have fired count as missed; set overrides clear.
      if (iEn && want[c] && (dc_q[c] != '0)) begin
        miss_d[c] = 1'b1;
      end

      if (!iEn) begin
        dc_d[c] = '0;
      end else if (accept[c]) begin
        dc_d[c] = iDead;
      end else if (dc_q[c] != '0) begin
        dc_d[c] = dc_q[c] - DC_ONE;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int c = 0; c < NCH; c++) begin
        sync_q[c] <= '0;
        fc_q[c]   <= '0;
        dc_q[c]   <= '0;
      end
      lvl_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      evt_q  <= '0;
      miss_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        sync_q[c] <= {sync_q[c][SYNC-2:0], iHit[c]};
        fc_q[c]   <= fc_d[c];
        dc_q[c]   <= dc_d[c];
      end
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      evt_q  <= rise_d | fall_d;
      miss_q <= miss_d;
    end
  end

  assign oRise  = rise_q;
  assign oFall  = fall_q;
  assign oEvent = evt_q;
  assign oLevel = lvl_q;
  assign oMiss  = miss_q;

endmodule

// File: tb/tb_tdc_edge_bank.sv
// tb/tb_tdc_edge_bank.sv - directed self-checking bench for tdc_edge_bank
module tb_tdc_edge_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] mode;
  logic [3:0] filt;
  logic [7:0] dead;
  logic       clr;
  logic [3:0] hit;
  logic [3:0] rise, fall, evt, lvl, miss;
  logic [3:0] acc;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  tdc_edge_bank #(.NCH(4), .SYNC(2), .FILT_W(4), .DEAD_W(8)) dut (
    .iClk(clk), .iRst_n(rst_n), .iEn(en), .iMode(mode), .iFilt(filt),
    .iDead(dead), .iClrMiss(clr), .iHit(hit),
    .oRise(rise), .oFall(fall), .oEvent(evt), .oLevel(lvl), .oMiss(miss)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 8'hFF; filt = 4'd0; dead = 8'd0;
    clr = 1'b0; hit = 4'h0;
    ticks(2);
    chk("reset_rise",  8'(rise), 8'h00);
    chk("reset_event", 8'(evt),  8'h00);
    chk("reset_level", 8'(lvl),  8'h00);
    chk("reset_miss",  8'(miss), 8'h00);
    rst_n = 1'b1;
    ticks(3);

    // ch0 high for 10 samples, no filter, no holdoff
    hit[0] = 1'b1;
    tick(); chk("t1_e0_rise", 8'(rise), 8'h00);
    tick(); chk("t1_e1_rise", 8'(rise), 8'h00);
    tick();
    chk("t1_e2_rise",  8'(rise), 8'h01);
    chk("t1_e2_event", 8'(evt),  8'h01);
    chk("t1_e2_fall",  8'(fall), 8'h00);
    chk("t1_e2_level", 8'(lvl),  8'h01);
    tick(); chk("t1_e3_rise", 8'(rise), 8'h00);
    ticks(6);
    hit[0] = 1'b0;
    tick();
    tick(); chk("t1_e11_fall", 8'(fall), 8'h00);
    tick();
    chk("t1_e12_fall",  8'(fall), 8'h01);
    chk("t1_e12_level", 8'(lvl),  8'h00);
    chk("t1_miss",      8'(miss), 8'h00);
    ticks(3);

    // glitch filter of 4 on ch1: 3-cycle pulse absorbed, 4-cycle pulse passes
    filt = 4'd4;
    ticks(2);
    acc = '0;
    hit[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) hit[1] = 1'b0;
      tick();
      acc = acc | evt;
    end
    chk("t2_short_event", 8'(acc), 8'h00);
    chk("t2_short_level", 8'(lvl), 8'h00);
    hit[1] = 1'b1;
    ticks(4);
    hit[1] = 1'b0;
    tick(); chk("t2_e4_rise", 8'(rise), 8'h00);
    tick();
    chk("t2_e5_rise",  8'(rise), 8'h02);
    chk("t2_e5_level", 8'(lvl),  8'h02);
    ticks(3); chk("t2_e8_fall", 8'(fall), 8'h00);
    tick();
    chk("t2_e9_fall",  8'(fall), 8'h02);
    chk("t2_e9_level", 8'(lvl),  8'h00);
    filt = 4'd0;
    ticks(3);

    // holdoff of 5 on ch2 (rise only); ch3 off
    dead = 8'd5;
    mode = 8'b00_01_11_11;
    ticks(2);
    hit[2] = 1'b1; tick();
    hit[2] = 1'b0; tick();
    tick(); chk("t3_e2_rise", 8'(rise), 8'h04);
    hit[2] = 1'b1;
    tick(); chk("t3_e3_fall", 8'(fall), 8'h00);
    tick();
    hit[2] = 1'b0;
    tick();
    chk("t3_e5_rise", 8'(rise), 8'h00);
    chk("t3_e5_miss", 8'(miss), 8'h04);
    hit[2] = 1'b1;
    ticks(2);
    tick();
    chk("t3_e8_rise", 8'(rise), 8'h04);
    ticks(8);

    // ch3 mode off: edges produce nothing, no miss
    acc = '0;
    hit[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) hit[3] = 1'b0;
      tick();
      acc = acc | evt;
    end
    chk("t4_off_event", 8'(acc & 4'h8),  8'h00);
    chk("t4_off_miss",  8'(miss & 4'h8), 8'h00);
    // ch3 fall only
    mode = 8'b10_01_11_11;
    tick();
    hit[3] = 1'b1;
    ticks(2);
    tick();
    chk("t4_g2_rise",  8'(rise), 8'h00);
    chk("t4_g2_level", 8'(lvl & 4'h8), 8'h08);
    tick();
    hit[3] = 1'b0;
    ticks(2); chk("t4_g5_fall", 8'(fall), 8'h00);
    tick();
    chk("t4_g6_fall",  8'(fall), 8'h08);
    chk("t4_g6_event", 8'(evt),  8'h08);
    ticks(8);

    // miss clear: clear alone on ch0, set+clear same cycle on ch2
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t5_clear", 8'(miss), 8'h00);
    hit[0] = 1'b1; hit[2] = 1'b0; tick();
    hit[0] = 1'b0; hit[2] = 1'b1; tick();
    hit[2] = 1'b0;
    tick(); chk("t5_f2_rise", 8'(rise), 8'h01);
    hit[2] = 1'b1;
    tick();
    chk("t5_f3_rise", 8'(rise), 8'h04);
    chk("t5_f3_miss", 8'(miss), 8'h01);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_f5_miss", 8'(miss), 8'h04);

    // reset mid-pulse with all hits high, then release
    mode = 8'hFF;
    dead = 8'd0;
    hit = 4'hF;
    tick();
    tick(); chk("t6_e1_rise", 8'(rise), 8'h00);
    tick(); chk("t6_e2_rise", 8'(rise), 8'h0B);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rise",  8'(rise), 8'h00);
    chk("t6_rst_event", 8'(evt),  8'h00);
    chk("t6_rst_level", 8'(lvl),  8'h00);
    chk("t6_rst_miss",  8'(miss), 8'h00);
    ticks(2);
    rst_n = 1'b1;
    tick(); chk("t6_r0_rise", 8'(rise), 8'h00);
    tick(); chk("t6_r1_rise", 8'(rise), 8'h00);
    tick();
    chk("t6_r2_rise",  8'(rise), 8'h0F);
    chk("t6_r2_level", 8'(lvl),  8'h0F);
    tick(); chk("t6_r3_rise", 8'(rise), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tdc_edge_bank.md
Name: tdc_edge_bank

Overview:
- Parametrised multi-channel successor of the single-channel hit edge detector in the TDC front end.
- Per channel: multi-stage synchroniser, programmable glitch filter, rise/fall/both/off mode select, dead-time holdoff, and a sticky missed-edge flag.
- Sits between the raw hit pins and the TDC capture/timestamp logic; its one-cycle event pulses trigger capture.

Parameters:
- NCH, 4, number of hit channels (>=1).
- SYNC, 2, synchroniser depth in flops (>=2).
- FILT_W, 4, width of the glitch-filter threshold and counter.
- DEAD_W, 8, width of the dead-time threshold and counter.

Ports:
- iClk  in  1  sampling clock; all logic on rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iEn  in  1  global enable for event generation.
- iMode  in  2*NCH  per-channel mode, bits [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both.
- iFilt  in  FILT_W  consecutive cycles required to accept a level change; 0 and 1 are equivalent (no filtering).
- iDead  in  DEAD_W  holdoff cycles after an accepted event; 0 means no holdoff.
- iClrMiss  in  1  clears all oMiss bits.
- iHit  in  NCH  asynchronous hit inputs.
- oRise  out  NCH  one-cycle pulse on an accepted rising edge.
- oFall  out  NCH  one-cycle pulse on an accepted falling edge.
- oEvent  out  NCH  oRise | oFall, registered.
- oLevel  out  NCH  filtered level L.
- oMiss  out  NCH  sticky flag: an enabled edge was suppressed by holdoff.

Behaviour:
- Reset (asynchronous, iRst_n=0): all synchroniser flops, L, filter counters fc, dead counters dc, oRise, oFall, oEvent, oLevel and oMiss go to 0 immediately.
- Synchroniser: SYNC-flop chain per channel; its last stage is s.
- Filter, per channel, each cycle:
  - If s==L: fc<=0.
  - Otherwise, if fc+1 >= max(iFilt,1): L<=s, fc<=0, and a raw edge is flagged (rise if s=1, fall if s=0).
  - Otherwise: fc<=fc+1.
  - A pulse shorter than iFilt cycles at s is absorbed and does not change L.
- Raw edge gating, evaluated in the cycle the raw edge is flagged:
  - Accept when iEn=1, the mode enables that edge type, and dc==0.
  - Disabled by mode or by iEn=0: silently dropped. dc is not loaded and oMiss is not set.
  - Enabled but dc!=0: dropped, and oMiss[c]<=1.
- Accepted edge:
  - oRise or oFall is high for exactly one cycle, registered on the same clock edge that updates L.
  - oEvent follows the same timing.
  - dc<=iDead.
- Dead counter: when dc!=0 and no edge is accepted, dc<=dc-1. After an accept at edge E, the earliest next accept is at edge E+iDead+1.
- Latency: a level change on iHit first sampled at edge 0 with stable input gives a pulse high in the cycle after edge SYNC-1+max(iFilt,1). With SYNC=2 and iFilt=0 the pulse is visible after edge 2.
- oMiss clear: iClrMiss clears every oMiss bit. For a channel with a set condition in the same cycle, set wins and that bit stays 1.
- iEn=0:
  - Synchronisers and filters keep tracking, so re-enabling never produces a stale edge.
  - dc is forced to 0.
  - Pulse outputs are 0.
  - oLevel remains valid.
- Run-time programming:
  - iMode and iFilt changes apply from the next cycle.
  - A partially advanced fc is kept and compared against the new threshold.
  - A running dc is unaffected by a new iDead value.
- Channel independence: channels are fully independent, so simultaneous edges on several channels all pulse in the same cycle.
- Reset release with iHit high: L rises after the normal latency and a rise event is generated if enabled. This is the required behaviour.
- Rise and fall are never both high on one channel in the same cycle.

Test Plan:
- SYNC=2, iFilt=0, iDead=0, iMode=11 (both), iEn=1; ch0 high for 10 cycles then low -> ch0: oRise pulse after edge 2, oFall 10 cycles later, oMiss=0, other channels idle.
- iFilt=4; ch1 pulses of 3 cycles then 4 cycles -> the 3-cycle pulse gives no event and oLevel[1] stays 0; the 4-cycle pulse gives one oRise and one oFall, each at the normal latency +3 cycles.
- iDead=5, iMode ch2=01 (rise); rising edges at s spaced 3 cycles (filter 0) -> first accepted, second suppressed with oMiss[2]=1; an edge arriving 6 cycles after the first accept is accepted.
- iMode ch3=00 with edges during a running dc -> no pulses and oMiss[3] stays 0; switch to 10 (fall) -> only falling edges pulse.
- oMiss set and iClrMiss in the same cycle on ch2, clear alone on ch0 -> oMiss[2]=1, oMiss[0]=0.
- Assert iRst_n=0 mid-pulse with iHit high on all channels, then release -> outputs 0 during reset; one oRise per enabled channel after SYNC+max(iFilt,1)-1 edges past release.
